pattern_scheduler: RTL

- Sequences the display's pattern generators, such as the vertical-scan pattern, and owns the single path into the row driver.
- Muxes one of NUM_PATTERNS generator outputs onto the row/address bus.
- Rotates patterns on a dwell timer or on a manual request, and only switches at a frame boundary (after row address 15).
- Holds unselected generators in reset and supplies the shared colour code.

---
 rtl/pattern_scheduler.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pattern_scheduler.sv
// Pattern scheduler: muxes one of NUM_PATTERNS generators onto the row driver and
// rotates them at frame boundaries. Define PATTERN_SCHED_LFSR_COLOUR_EN for LFSR colour.
module pattern_scheduler #(
  parameter int NUM_PATTERNS   = 4,
  parameter int DWELL_CYCLES   = 50_000_000,
  parameter int RESTART_CYCLES = 2,
  parameter int GL_RGB_ROW_W   = 24,
  localparam int SEL_W   = (NUM_PATTERNS > 2) ? $clog2(NUM_PATTERNS) : 1,
  localparam int TIMER_W = $clog2(DWELL_CYCLES + 1)
) (
  input  logic                                 clk_in,
  input  logic                                 reset_in,
  input  logic [NUM_PATTERNS*GL_RGB_ROW_W-1:0] pattern_row_in,
  input  logic [NUM_PATTERNS*4-1:0]            pattern_addr_in,
  output logic [NUM_PATTERNS-1:0]              pattern_n_reset_out,
  input  logic                                 next_req_in,
  input  logic                                 hold_in,
  output logic [2:0]                           colour_out,
  output logic [SEL_W-1:0]                     pattern_sel_out,
  output logic [GL_RGB_ROW_W-1:0]              row_out,
  output logic [3:0]                           row_address_out,
  output logic                                 switch_busy_out
);

  localparam int RC_W = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_PEND    = 2'd1;
  localparam logic [1:0] ST_RESTART = 2'd2;

  logic [1:0]              state;
  logic [RC_W-1:0]         rcnt;
  logic [TIMER_W-1:0]      timer;
  logic [SEL_W-1:0]        sel;
  logic [SEL_W-1:0]        sel_next;
  logic [2:0]              colour;
  logic [2:0]              colour_next;
  logic [GL_RGB_ROW_W-1:0] row_sel;
  logic [3:0]              addr_sel;
  logic                    sel_wraps;

  always_comb begin
    row_sel  = '0;
    addr_sel = '0;
    for (int unsigned i = 0; i < NUM_PATTERNS; i++) begin
      if (sel == SEL_W'(i)) begin
        row_sel  = pattern_row_in[i*GL_RGB_ROW_W +: GL_RGB_ROW_W];
        addr_sel = pattern_addr_in[i*4 +: 4];
      end
    end
  end

  always_comb begin
    pattern_n_reset_out = '0;
    if (state != ST_RESTART) begin
      for (int unsigned i = 0; i < NUM_PATTERNS; i++) begin
        pattern_n_reset_out[i] = (sel == SEL_W'(i));
      end
    end
  end

  assign sel_wraps = (sel == SEL_W'(NUM_PATTERNS - 1));
  assign sel_next  = sel_wraps ? '0 : sel + SEL_W'(1);

  always_comb begin
`ifdef PATTERN_SCHED_LFSR_COLOUR_EN
    colour_next = {colour[1:0], colour[2] ^ colour[1]};
`else
    // 3'b000 is skipped so generators always receive a visible colour
    colour_next = colour;
    if (sel_wraps) begin
      colour_next = (colour == 3'b111) ? 3'b001 : colour + 3'd1;
    end
`endif
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state           <= ST_RESTART;
      rcnt            <= '0;
      timer           <= '0;
      sel             <= '0;
      colour          <= 3'b001;
      row_out         <= '0;
      row_address_out <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          row_out         <= row_sel;
          row_address_out <= addr_sel;
          if (!hold_in) begin
            timer <= timer + TIMER_W'(1);
          end
          if ((!hold_in && timer == TIMER_W'(DWELL_CYCLES - 1)) || next_req_in) begin
            state <= ST_PEND;
          end
        end
        ST_PEND: begin
          row_out         <= row_sel;
          row_address_out <= addr_sel;
          // Last row of the frame goes out on the same edge the switch is taken
          if (addr_sel == 4'hF) begin
            state  <= ST_RESTART;
            sel    <= sel_next;
            rcnt   <= '0;
            colour <= colour_next;
          end
        end
        ST_RESTART: begin
          row_out         <= '0;
          row_address_out <= row_address_out + 4'd1;
          if (rcnt == RC_W'(RESTART_CYCLES - 1)) begin
            state <= ST_RUN;
            timer <= '0;
          end else begin
            rcnt <= rcnt + RC_W'(1);
          end
        end
        default: state <= ST_RESTART;
      endcase
    end
  end

  assign switch_busy_out = (state != ST_RUN);
  assign pattern_sel_out = sel;
  assign colour_out      = colour;

endmodule
